// File: rtl/uart_tx_comp.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_comp
// Purpose  : Buffered UART transmitter with a 16-deep write FIFO, baud tick
//            generator and registered serial output.
// Revision : 1.0
// ============================================================================
module uart_tx_comp #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 5,
    parameter int ADDR_W  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_uart,
    input  logic [DBIT-1:0] w_data,
    output logic            tx,
    output logic            s_tick,
    output logic            tx_full,
    output logic            tx_empty,
    output logic            tx_busy
);

    localparam int c_baud_w = (DVSR > 1)    ? $clog2(DVSR)    : 1;
    localparam int c_tick_w = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
    localparam int c_bit_w  = (DBIT > 1)    ? $clog2(DBIT)    : 1;
    localparam int c_depth  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              r_state, w_state_next;
    logic [c_baud_w-1:0] r_baud;
    logic [c_tick_w-1:0] r_tick, w_tick_next;
    logic [c_bit_w-1:0]  r_bit, w_bit_next;
    logic [DBIT-1:0]     r_shift, w_shift_next;
    logic                r_tx, w_tx_next;
    logic                w_baud_clr;
    logic                w_s_tick;
    logic                w_pop;
    logic                w_push;
    logic                w_tick_last;

    logic [DBIT-1:0]     r_mem [c_depth];
    logic [ADDR_W-1:0]   r_wptr, r_rptr;
    logic [ADDR_W-1:0]   w_wptr_inc, w_rptr_inc;
    logic                r_full, r_empty;

    // ------------------------------------------------------------------
    // Baud tick generator
    // ------------------------------------------------------------------
    assign w_s_tick = (r_baud == c_baud_w'(DVSR - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud <= '0;
        end else if (w_baud_clr || w_s_tick) begin
            r_baud <= '0;
        end else begin
            r_baud <= r_baud + c_baud_w'(1);
        end
    end

    // ------------------------------------------------------------------
    // Transmit FIFO; a push is accepted while full only if the FSM pops
    // in the same cycle, which keeps the occupancy unchanged.
    // ------------------------------------------------------------------
    assign w_push     = wr_uart && (!r_full || w_pop);
    assign w_wptr_inc = r_wptr + ADDR_W'(1);
    assign w_rptr_inc = r_rptr + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wptr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr <= w_wptr_inc;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_inc;
            end
            case ({w_push, w_pop})
                2'b10: begin
                    r_empty <= 1'b0;
                    r_full  <= (w_wptr_inc == r_rptr);
                end
                2'b01: begin
                    r_full  <= 1'b0;
                    r_empty <= (w_rptr_inc == r_wptr);
                end
                default: begin
                    r_full  <= r_full;
                    r_empty <= r_empty;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    assign w_tick_last = (r_tick == c_tick_w'(SB_TICK - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_tick  <= w_tick_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tick_next  = r_tick;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_baud_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_empty) begin
                    w_pop        = 1'b1;
                    w_baud_clr   = 1'b1;
                    w_shift_next = r_mem[r_rptr];
                    w_tick_next  = '0;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_s_tick) begin
                    if (w_tick_last) begin
                        w_tick_next  = '0;
                        w_bit_next   = '0;
                        w_state_next = S_DATA;
                    end else begin
                        w_tick_next = r_tick + c_tick_w'(1);
                    end
                end
            end
            S_DATA: begin
                if (w_s_tick) begin
                    if (w_tick_last) begin
                        w_tick_next  = '0;
                        w_shift_next = r_shift >> 1;
                        if (r_bit == c_bit_w'(DBIT - 1)) begin
                            w_state_next = S_STOP;
                        end else begin
                            w_bit_next = r_bit + c_bit_w'(1);
                        end
                    end else begin
                        w_tick_next = r_tick + c_tick_w'(1);
                    end
                end
            end
            S_STOP: begin
                if (w_s_tick) begin
                    if (w_tick_last) begin
                        w_tick_next  = '0;
                        w_state_next = S_IDLE;
                    end else begin
                        w_tick_next = r_tick + c_tick_w'(1);
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Line level is derived from the next state so tx changes on the same
    // edge as the state register and never glitches.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    assign tx       = r_tx;
    assign s_tick   = w_s_tick;
    assign tx_full  = r_full;
    assign tx_empty = r_empty;
    assign tx_busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_comp.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_comp
// Purpose  : Scoreboard bench for uart_tx_comp; a serial monitor decodes tx
//            frames and compares them with bytes queued by the stimulus.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_comp;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       tx;
    logic       s_tick;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_busy;

    int         n_vec  = 0;
    int         n_miss = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    uart_tx_comp #(
        .DBIT    (8),
        .SB_TICK (16),
        .DVSR    (5),
        .ADDR_W  (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_uart  (wr_uart),
        .w_data   (w_data),
        .tx       (tx),
        .s_tick   (s_tick),
        .tx_full  (tx_full),
        .tx_empty (tx_empty),
        .tx_busy  (tx_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input string name, input int limit);
        int c;
        c = 0;
        while ((tx_busy || !tx_empty || sb.size() != 0) && c < limit) begin
            @(negedge clk);
            c++;
        end
        chk(name, (c < limit), 1);
    endtask

    // Serial monitor: first low sample is cycle 0; sample mid-bit every 80.
    initial begin : monitor
        bit         active;
        int         cnt;
        logic [7:0] rx;
        active = 1'b0;
        cnt    = 0;
        rx     = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1;
                    cnt    = 0;
                end
            end else begin
                cnt++;
                if (cnt == 40) begin
                    chk("start_bit", tx, 0);
                end else if (cnt >= 120 && cnt <= 680 && ((cnt - 40) % 80) == 0) begin
                    rx[(cnt - 120) / 80] = tx;
                end else if (cnt == 760) begin
                    chk("stop_bit", tx, 1);
                    chk("frame_expected", (sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        chk("frame_data", rx, sb.pop_front());
                    end
                    active = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int cnt;
        reset   = 1'b1;
        wr_uart = 1'b0;
        w_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_s_tick", s_tick, 0);
        chk("rst_empty", tx_empty, 1);
        chk("rst_full", tx_full, 0);
        chk("rst_busy", tx_busy, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_tx", tx, 1);

        // Single byte 0xCD: latency, tick phase and frame length
        wr_uart = 1'b1;
        w_data  = 8'hCD;
        sb.push_back(8'hCD);
        @(negedge clk);
        wr_uart = 1'b0;
        chk("empty_after_push", tx_empty, 0);
        chk("tx_high_before_start", tx, 1);
        @(negedge clk);
        chk("tx_low_start", tx, 0);
        chk("empty_after_pop", tx_empty, 1);
        cnt = 0;
        while (tx_busy && cnt < 2000) begin
            if (cnt == 3) chk("tick_before_first", s_tick, 0);
            if (cnt == 4) chk("first_tick", s_tick, 1);
            if (cnt == 8) chk("tick_gap", s_tick, 0);
            if (cnt == 9) chk("second_tick", s_tick, 1);
            cnt++;
            @(negedge clk);
        end
        chk("busy_len_single", cnt, 800);
        wait_drain("drain_single", 200);

        // Back-to-back 0xCD, 0x5A: one idle cycle between frames
        wr_uart = 1'b1;
        w_data  = 8'hCD;
        sb.push_back(8'hCD);
        @(negedge clk);
        w_data = 8'h5A;
        sb.push_back(8'h5A);
        @(negedge clk);
        wr_uart = 1'b0;
        cnt = 0;
        while (tx_busy && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        chk("busy_len_first", cnt, 800);
        cnt = 0;
        while (!tx_busy && cnt < 10) begin
            cnt++;
            @(negedge clk);
        end
        chk("idle_gap", cnt, 1);
        cnt = 0;
        while (tx_busy && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        chk("busy_len_second", cnt, 800);
        wait_drain("drain_pair", 200);

        // Overflow: 18 writes, 0x11 dropped
        for (int i = 0; i < 18; i++) begin
            wr_uart = 1'b1;
            w_data  = 8'(i);
            if (i < 17) sb.push_back(8'(i));
            @(negedge clk);
            if (i == 15) chk("full_after_16", tx_full, 0);
            if (i == 16) chk("full_after_17", tx_full, 1);
            if (i == 17) chk("full_after_drop", tx_full, 1);
        end
        wr_uart = 1'b0;

        // Push in the pop cycle while full
        cnt = 0;
        while (tx_busy && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        chk("full_before_pop", tx_full, 1);
        wr_uart = 1'b1;
        w_data  = 8'h77;
        sb.push_back(8'h77);
        @(negedge clk);
        wr_uart = 1'b0;
        chk("full_simul", tx_full, 1);
        chk("busy_after_pop", tx_busy, 1);
        wait_drain("drain_overflow", 17 * 800 + 500);

        // Reset in the middle of 0xA5 with three bytes queued
        wr_uart = 1'b1;
        w_data  = 8'hA5;
        @(negedge clk);
        w_data = 8'h11;
        @(negedge clk);
        w_data = 8'h22;
        @(negedge clk);
        w_data = 8'h33;
        @(negedge clk);
        wr_uart = 1'b0;
        repeat (200) @(negedge clk);
        chk("busy_before_reset", tx_busy, 1);
        reset   = 1'b1;
        wr_uart = 1'b1;
        w_data  = 8'h99;
        @(negedge clk);
        chk("abort_tx", tx, 1);
        chk("abort_empty", tx_empty, 1);
        chk("abort_busy", tx_busy, 0);
        chk("abort_full", tx_full, 0);
        @(negedge clk);
        reset   = 1'b0;
        wr_uart = 1'b0;
        @(negedge clk);
        chk("wr_during_reset_ignored", tx_empty, 1);
        cnt = 0;
        repeat (1000) begin
            if (tx_busy) cnt++;
            @(negedge clk);
        end
        chk("no_frames_after_reset", cnt, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_comp.md
UART_TX_COMP -- requirements
Module: uart_tx_comp

Interface
REQ-001 Parameters (name, default, meaning): DBIT, 8, data bits per frame; SB_TICK, 16, oversampling ticks per bit; DVSR, 5, clocks per tick; ADDR_W, 4, FIFO address width (depth 2^ADDR_W = 16).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 wr_uart  input  1  write strobe; one byte pushed per cycle asserted.
REQ-005 w_data  input  DBIT  byte to enqueue, sampled with wr_uart.
REQ-006 tx  output  1  serial line, idle high, drives UART_comp rx_data.
REQ-007 s_tick  output  1  baud tick, one clk wide.
REQ-008 tx_full  output  1  FIFO full.
REQ-009 tx_empty  output  1  FIFO empty.
REQ-010 tx_busy  output  1  high whenever FSM not in IDLE.

Function
REQ-011 Baud counter SHALL count 0..DVSR-1 and wrap; s_tick SHALL be high exactly in the cycle the count equals DVSR-1.
REQ-012 Baud counter SHALL be cleared to 0 on the IDLE->START transition, so every bit lasts exactly SB_TICK*DVSR clocks (80 at defaults).
REQ-013 FIFO SHALL store a byte when wr_uart=1 and tx_full=0; writes while tx_full=1 SHALL be dropped with no state change.
REQ-014 FIFO SHALL be popped only by the FSM in IDLE when tx_empty=0; simultaneous push and pop SHALL keep count unchanged, including when full.
REQ-015 Pointers SHALL wrap modulo 2^ADDR_W; tx_full/tx_empty SHALL be registered and update on the edge after the causing push/pop.
REQ-016 FSM states: IDLE, START, DATA, STOP.
REQ-017 IDLE: tx=1; if tx_empty=0, pop head into shift register, clear tick count, go START.
REQ-018 START: tx=0 for SB_TICK ticks, then clear bit index, go DATA.
REQ-019 DATA: tx=shift[0] for SB_TICK ticks per bit, shift right, LSB first; after DBIT bits go STOP.
REQ-020 STOP: tx=1 for SB_TICK ticks, then go IDLE.
REQ-021 tx SHALL be a registered output with no combinational glitches.
REQ-022 Latency: wr_uart sampled at edge k into empty FIFO while IDLE -> tx low after edge k+1; first data bit after edge k+81; frame 800 clocks at defaults.
REQ-023 Back-to-back frames: one IDLE cycle between STOP and next START; stop bit therefore 81 clocks when FIFO non-empty.
REQ-024 wr_uart during a frame SHALL never alter the byte being shifted.

Reset
REQ-025 While reset=1 at a rising edge: state=IDLE, tx=1, s_tick=0, baud and tick counters 0, FIFO pointers 0, tx_empty=1, tx_full=0, tx_busy=0.
REQ-026 Reset mid-frame SHALL abort the frame (tx=1 after the edge) and discard all FIFO contents; wr_uart during reset SHALL be ignored.

Verification
REQ-027 Single byte: write 0xCD once -> tx low 80 clocks, then 1,0,1,1,0,0,1,1 for 80 clocks each, then high; tx_busy high for 800 clocks.
REQ-028 Loopback: tx wired to UART_comp rx_data (DVSR=5), write 0xCD then 0x5A -> UART_comp FIFO reads 0xCD then 0x5A, empty toggles correctly.
REQ-029 Overflow: 18 consecutive writes 0x00..0x11 while IDLE -> 0x00 in shifter, tx_full high after 17th write, 0x11 dropped; 17 frames 0x00..0x10 transmitted in order.
REQ-030 Simultaneous: with FIFO full, wr_uart in the pop cycle -> byte accepted, tx_full stays 1, no data lost.
REQ-031 Reset mid-DATA of 0xA5 with 3 bytes queued -> tx=1 next cycle, tx_empty=1, no further frames without new writes.
REQ-032 Tick check: s_tick period exactly 5 clocks during frame; first tick 5 clocks after START entry.
